// File: rtl/planificador_elevador.sv
// SCAN request scheduler and motion sequencer for a three-floor elevator.
// It latches calls per floor, times travel and door intervals, and drives the motor and door commands.
module planificador_elevador #(
    parameter int T_VIAJE  = 8,
    parameter int T_PUERTA = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] llamada,
    output logic       motorsubir,
    output logic       motorbajar,
    output logic       puerta_abierta,
    output logic [1:0] piso_actual,
    output logic [2:0] pendientes,
    output logic       ocupado
);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        SUBIENDO = 2'd1,
        BAJANDO  = 2'd2,
        PUERTA   = 2'd3
    } estado_t;

    localparam logic [7:0] CARGA_VIAJE  = 8'(T_VIAJE - 1);
    localparam logic [7:0] CARGA_PUERTA = 8'(T_PUERTA - 1);

    estado_t    estado, estado_sig;
    logic [1:0] piso, piso_sig, piso_nuevo;
    logic [2:0] pend, pend_sig, borrar;
    logic       dir_subir, dir_subir_sig;
    logic [7:0] timer, timer_sig;
    logic       hay_aqui, hay_arriba, hay_abajo;

    // Request masks by floor code; bit0 is floor 1.
    function automatic logic [2:0] mascara_piso(input logic [1:0] p);
        case (p)
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            2'b11:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] mascara_arriba(input logic [1:0] p);
        case (p)
            2'b01:   return 3'b110;
            2'b10:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] mascara_abajo(input logic [1:0] p);
        case (p)
            2'b10:   return 3'b001;
            2'b11:   return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    assign hay_aqui   = |(pend & mascara_piso(piso));
    assign hay_arriba = |(pend & mascara_arriba(piso));
    assign hay_abajo  = |(pend & mascara_abajo(piso));

    // NOTE: every variable gets its hold value before the case, so no path can infer a latch.
    always_comb begin
        estado_sig    = estado;
        piso_sig      = piso;
        piso_nuevo    = piso;
        dir_subir_sig = dir_subir;
        timer_sig     = timer;
        borrar        = 3'b000;

        case (estado)
            REPOSO: begin
                if (hay_aqui) begin
                    estado_sig = PUERTA;
                    borrar     = mascara_piso(piso);
                    timer_sig  = CARGA_PUERTA;
                end else if (hay_arriba && (dir_subir || !hay_abajo)) begin
                    estado_sig    = SUBIENDO;
                    dir_subir_sig = 1'b1;
                    timer_sig     = CARGA_VIAJE;
                end else if (hay_abajo) begin
                    estado_sig    = BAJANDO;
                    dir_subir_sig = 1'b0;
                    timer_sig     = CARGA_VIAJE;
                end
            end

            SUBIENDO: begin
                if (timer != 8'd0) begin
                    timer_sig = timer - 8'd1;
                end else if (piso >= 2'b11 || piso == 2'b00) begin
                    estado_sig = REPOSO;
                end else begin
                    piso_nuevo = piso + 2'b01;
                    piso_sig   = piso_nuevo;
                    if (|(pend & mascara_piso(piso_nuevo))) begin
                        estado_sig = PUERTA;
                        borrar     = mascara_piso(piso_nuevo);
                        timer_sig  = CARGA_PUERTA;
                    end else if (|(pend & mascara_arriba(piso_nuevo))) begin
                        timer_sig = CARGA_VIAJE;
                    end else begin
                        estado_sig = REPOSO;
                    end
                end
            end

            BAJANDO: begin
                if (timer != 8'd0) begin
                    timer_sig = timer - 8'd1;
                end else if (piso <= 2'b01) begin
                    estado_sig = REPOSO;
                end else begin
                    piso_nuevo = piso - 2'b01;
                    piso_sig   = piso_nuevo;
                    if (|(pend & mascara_piso(piso_nuevo))) begin
                        estado_sig = PUERTA;
                        borrar     = mascara_piso(piso_nuevo);
                        timer_sig  = CARGA_PUERTA;
                    end else if (|(pend & mascara_abajo(piso_nuevo))) begin
                        timer_sig = CARGA_VIAJE;
                    end else begin
                        estado_sig = REPOSO;
                    end
                end
            end

            PUERTA: begin
                // Calls for the open floor are swallowed for the whole door interval.
                borrar = mascara_piso(piso);
                if (timer == 8'd0) begin
                    estado_sig = REPOSO;
                end else begin
                    timer_sig = timer - 8'd1;
                end
            end

            default: estado_sig = REPOSO;
        endcase
    end

    assign pend_sig = (pend | llamada) & ~borrar;

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= REPOSO;
            piso      <= 2'b01;
            pend      <= 3'b000;
            dir_subir <= 1'b1;
            timer     <= 8'd0;
        end else begin
            estado    <= estado_sig;
            piso      <= piso_sig;
            pend      <= pend_sig;
            dir_subir <= dir_subir_sig;
            timer     <= timer_sig;
        end
    end

    assign motorsubir     = (estado == SUBIENDO);
    assign motorbajar     = (estado == BAJANDO);
    assign puerta_abierta = (estado == PUERTA);
    assign piso_actual    = piso;
    assign pendientes     = pend;
    assign ocupado        = (estado != REPOSO) || (pend != 3'b000);

endmodule

// File: tb/tb_planificador_elevador.sv
// Bench for planificador_elevador: directed scenarios plus random calls, all checked against a floor-level model.
module tb_planificador_elevador;

    localparam int TV = 8;
    localparam int TP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] llamada = 3'b000;
    logic       motorsubir, motorbajar, puerta_abierta, ocupado;
    logic [1:0] piso_actual;
    logic [2:0] pendientes;

    int n_cmp = 0;
    int n_err = 0;

    planificador_elevador #(.T_VIAJE(TV), .T_PUERTA(TP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .llamada(llamada),
        .motorsubir(motorsubir),
        .motorbajar(motorbajar),
        .puerta_abierta(puerta_abierta),
        .piso_actual(piso_actual),
        .pendientes(pendientes),
        .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    // Reference: floor number, requested floors, travel sense (+1/-1/0), door flag, cycles left.
    int       m_floor;
    bit [3:1] m_req;
    int       m_move;
    bit       m_door;
    bit       m_pref_up;
    int       m_left;

    int up_cnt, down_cnt, door_cnt, door_at2;

    task automatic model_reset();
        m_floor = 1; m_req = '0; m_move = 0; m_door = 0; m_pref_up = 1; m_left = 0;
    endtask

    task automatic model_step(input logic [2:0] c);
        bit [3:1] nreq;
        bit any_above, any_below, further;
        int nf;
        nreq = m_req | c;
        if (m_door) begin
            nreq[m_floor] = 1'b0;
            if (m_left == 0) m_door = 0; else m_left--;
        end else if (m_move != 0) begin
            if (m_left > 0) m_left--;
            else begin
                nf = m_floor + m_move;
                if (nf < 1 || nf > 3) m_move = 0;
                else begin
                    m_floor = nf;
                    further = 0;
                    for (int f = nf + m_move; f >= 1 && f <= 3; f += m_move)
                        if (m_req[f]) further = 1;
                    if (m_req[nf]) begin
                        m_move = 0; m_door = 1; m_left = TP - 1; nreq[nf] = 1'b0;
                    end else if (further) m_left = TV - 1;
                    else m_move = 0;
                end
            end
        end else begin
            any_above = 0; any_below = 0;
            for (int f = 1; f <= 3; f++) begin
                if (f > m_floor && m_req[f]) any_above = 1;
                if (f < m_floor && m_req[f]) any_below = 1;
            end
            if (m_req[m_floor]) begin
                m_door = 1; m_left = TP - 1; nreq[m_floor] = 1'b0;
            end else if (any_above && (m_pref_up || !any_below)) begin
                m_move = 1; m_pref_up = 1; m_left = TV - 1;
            end else if (any_below) begin
                m_move = -1; m_pref_up = 0; m_left = TV - 1;
            end
        end
        m_req = nreq;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".subir"},  8'(motorsubir),     8'(m_move == 1));
        check({tag, ".bajar"},  8'(motorbajar),     8'(m_move == -1));
        check({tag, ".puerta"}, 8'(puerta_abierta), 8'(m_door));
        check({tag, ".piso"},   8'(piso_actual),    8'(m_floor));
        check({tag, ".pend"},   8'(pendientes),     8'(m_req));
        check({tag, ".ocup"},   8'(ocupado),        8'(m_move != 0 || m_door || m_req != 0));
    endtask

    // One clock: drive calls, advance the model at the edge, compare 1 time unit later.
    task automatic tick(input logic [2:0] c, input string tag);
        llamada = c;
        @(posedge clk);
        model_step(c);
        #1;
        check_all(tag);
        if (motorsubir) up_cnt++;
        if (motorbajar) down_cnt++;
        if (puerta_abierta) door_cnt++;
        if (puerta_abierta && piso_actual == 2'b10) door_at2++;
        llamada = 3'b000;
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(3'b000, tag);
    endtask

    task automatic clear_counts();
        up_cnt = 0; down_cnt = 0; door_cnt = 0; door_at2 = 0;
    endtask

    initial begin
        model_reset();
        clear_counts();

        // Reset held with calls toggling: nothing may latch.
        for (int i = 0; i < 4; i++) begin
            llamada = 3'(i + 3);
            @(posedge clk); #1;
            check("rst.subir", 8'(motorsubir), 8'd0);
            check("rst.puerta", 8'(puerta_abierta), 8'd0);
            check("rst.piso", 8'(piso_actual), 8'h01);
            check("rst.pend", 8'(pendientes), 8'h00);
        end
        llamada = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        run(3, "idle");
        check("idle.ocup", 8'(ocupado), 8'd0);

        // Floor 1 to 3 without stopping at 2.
        clear_counts();
        tick(3'b100, "f13");
        run(26, "f13");
        check("f13.up_cycles", 8'(up_cnt), 8'(2 * TV));
        check("f13.door_cycles", 8'(door_cnt), 8'(TP));
        check("f13.no_stop2", 8'(door_at2), 8'd0);
        check("f13.floor", 8'(piso_actual), 8'h03);

        // Call at the current floor, repeated while the door is open.
        clear_counts();
        tick(3'b100, "here");
        tick(3'b000, "here");
        tick(3'b100, "here_rep");
        run(6, "here");
        check("here.door_cycles", 8'(door_cnt), 8'(TP));
        check("here.no_motor", 8'(up_cnt + down_cnt), 8'd0);
        check("here.pend", 8'(pendientes), 8'h00);

        tick(3'b001, "home");
        run(30, "home");

        // Intermediate stop at floor 2 on the way up.
        clear_counts();
        tick(3'b100, "mid");
        run(2, "mid");
        tick(3'b010, "mid");
        run(36, "mid");
        check("mid.stop2", 8'(door_at2), 8'(TP));
        check("mid.door_cycles", 8'(door_cnt), 8'(2 * TP));
        check("mid.up_cycles", 8'(up_cnt), 8'(2 * TV));

        tick(3'b001, "home");
        run(30, "home");

        // SCAN: floor 1 call raised while heading up is served after floor 3.
        clear_counts();
        tick(3'b100, "scan");
        run(8, "scan");
        tick(3'b001, "scan");
        run(50, "scan");
        check("scan.down_cycles", 8'(down_cnt), 8'(2 * TV));
        check("scan.door_cycles", 8'(door_cnt), 8'(2 * TP));
        check("scan.floor", 8'(piso_actual), 8'h01);
        check("scan.pend", 8'(pendientes), 8'h00);

        // Asynchronous reset in the middle of upward travel.
        tick(3'b110, "arst");
        run(4, "arst");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst.subir", 8'(motorsubir), 8'd0);
        check("arst.piso", 8'(piso_actual), 8'h01);
        check("arst.pend", 8'(pendientes), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        run(3, "arst_idle");

        // Random calls, occasionally several at once.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) tick(3'($urandom_range(1, 7)), "rnd");
            else tick(3'b000, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
